game_sequencer: RTL and testbench
=================================

// Module: game_sequencer
// PURPOSE
// - Owns authoritative game state: board, ko board, turn, pass streak, move count.
// - Accepts move/pass requests from player input and pre-checks them.
// - Launches one board_updater transaction per legal-looking move, then commits or rejects.
// - Sits between input decoding (cursor/buttons) and the display/board_updater pair.
// PARAMETERS
// - TIMEOUT_CYCLES  1024  max cycles to wait for updater valid/invalid before abort
// - COUNT_W         9     width of move_count_out
// PORTS
// - clk_in              in   1          system clock; everything on posedge
// - rst_in              in   1          synchronous reset, ACTIVE-LOW
// - new_game_in         in   1          clear game; honoured only in IDLE or OVER
// - req_valid_in        in   1          request strobe; accepted when req_ready_out=1
// - req_ready_out       out  1          high only in IDLE
// - req_player_in       in   1          requesting colour (0 black, 1 white)
// - req_pass_in         in   1          1 = pass; req_move_in ignored
// - req_move_in         in   8          [7:4] row, [3:0] col
// - upd_start_out       out  1          one-cycle start pulse to board_updater
// - upd_turn_out        out  1          turn for updater; held stable ISSUE..WAIT
// - upd_move_out        out  8          latched move; held stable ISSUE..WAIT
// - upd_board_out       out  cell_t[9][9]  current board; held stable ISSUE..WAIT
// - upd_ko_out          out  cell_t[9][9]  ko board; held stable ISSUE..WAIT
// - upd_next_board_in   in   cell_t[9][9]  updater result
// - upd_valid_in        in   1          updater accepted move
// - upd_invalid_in      in   1          updater rejected move (ko/suicide)
// - board_out           out  cell_t[9][9]  committed board (= upd_board_out)
// - turn_out            out  1          side to move (0 black, 1 white)
// - ack_out             out  1          one-cycle pulse: request applied
// - nack_out            out  1          one-cycle pulse: request refused
// - nack_code_out       out  3          reason, valid with nack_out, held until next nack
// - game_over_out       out  1          two consecutive passes occurred
// - move_count_out      out  COUNT_W    committed stones played; saturates at all-ones
// BEHAVIOUR
// - Reset (rst_in=0): board/ko EMPTY, turn=0, pass_streak=0, count=0, all pulses 0,
//   nack_code=000, state IDLE. Mid-transaction reset aborts; the updater, reset from
//   the same net (inverted at top), also returns to WAITING.
// - Cell encoding: 00 empty, 01 black, 10 white, i.e. {turn,~turn}.
// - States: IDLE, CHECK, ISSUE, WAIT, COMMIT, PASS, REJECT, OVER.
// - IDLE: ready=1. valid&ready latches player/pass/move -> CHECK. new_game_in -> clear
//   as reset (takes priority over a same-cycle request).
// - CHECK (priority order): player!=turn -> REJECT 100; pass -> PASS; row>8 or col>8 ->
//   REJECT 000; board[row][col]!=00 -> REJECT 001; else -> ISSUE.
// - ISSUE: upd_start_out=1 for exactly this cycle; timer<=0 -> WAIT.
// - WAIT: upd_invalid_in -> REJECT 010 (wins if valid and invalid are both high);
//   upd_valid_in -> COMMIT; timer==TIMEOUT_CYCLES-1 -> REJECT 011; else timer++.
// - COMMIT (1 cycle): ko<=board, board<=upd_next_board_in, turn<=~turn,
//   count++ (saturating), pass_streak<=0, ack_out<=1 -> IDLE. New board and ack
//   become visible on the same edge.
// - PASS (1 cycle): ko<=board, board unchanged, turn<=~turn, pass_streak++, ack_out<=1;
//   if pass_streak was 1 -> OVER, else IDLE.
// - REJECT (1 cycle): nack_out<=1 and nack_code_out<=code; board/ko/turn/streak
//   unchanged -> IDLE.
// - OVER: game_over_out=1, ready=0, requests ignored (no nack). new_game_in -> clear, IDLE.
// - Latency: accept at edge N; immediate reject or pass ack at N+2; earliest commit
//   ack at N+3+updater latency.
// - Stray upd_valid_in/upd_invalid_in outside WAIT are ignored.
// STRUCTURE
// - go_pkg: cell_t (logic [1:0]), board_t, CELL_EMPTY/BLACK/WHITE, BOARD_DIM=9,
//   EMPTY_BOARD constant, nack_code_t {OFF_BOARD=000, OCCUPIED=001, ILLEGAL=010,
//   TIMEOUT=011, WRONG_PLAYER=100}.
// - State as a typedef enum, local to this module. No sub-module: board_updater is
//   instantiated beside this block at the top level, not inside it.
// TESTING
// - Reset then black move 0x44: upd_start pulse once, stub returns valid with [4][4]=01
//   -> ack, board_out[4][4]=01, turn=1, count=1.
// - White requests 0x44 onto that board -> nack code 001, no upd_start, turn stays 1.
// - Move 0x93 (row 9) -> nack 000; black request on white's turn -> nack 100.
// - Stub asserts upd_invalid 5 cycles after start -> nack 010; board/ko/turn unchanged.
// - Stub never responds with TIMEOUT_CYCLES=16 -> nack 011 at the 16th WAIT cycle, then
//   ready=1.
// - Black pass, white pass -> two acks, game_over=1, later requests ignored;
//   new_game_in -> EMPTY board, turn=0, count=0.

Source files
------------

// File: rtl/go_pkg.sv
// Shared Go types: 9x9 board of 2-bit cells and request nack codes.
// Imported by the sequencer and by the board updater at top level.
package go_pkg;

    localparam int BOARD_DIM = 9;

    typedef logic [1:0] cell_t;
    typedef cell_t [BOARD_DIM-1:0][BOARD_DIM-1:0] board_t;

    localparam cell_t  CELL_EMPTY  = 2'b00;
    localparam cell_t  CELL_BLACK  = 2'b01;
    localparam cell_t  CELL_WHITE  = 2'b10;
    localparam board_t EMPTY_BOARD = '0;

    typedef enum logic [2:0] {
        OFF_BOARD    = 3'b000,
        OCCUPIED     = 3'b001,
        ILLEGAL      = 3'b010,
        TIMEOUT      = 3'b011,
        WRONG_PLAYER = 3'b100
    } nack_code_t;

    function automatic cell_t stone_of(input logic turn);
        return {turn, ~turn};
    endfunction

endpackage

// File: rtl/game_sequencer.sv
// Authoritative game state: pre-checks requests, runs one board_updater
// transaction per plausible move, then commits or rejects it.
module game_sequencer
    import go_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int COUNT_W        = 9
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               new_game_in,
    input  logic               req_valid_in,
    output logic               req_ready_out,
    input  logic               req_player_in,
    input  logic               req_pass_in,
    input  logic [7:0]         req_move_in,
    output logic               upd_start_out,
    output logic               upd_turn_out,
    output logic [7:0]         upd_move_out,
    output board_t             upd_board_out,
    output board_t             upd_ko_out,
    input  board_t             upd_next_board_in,
    input  logic               upd_valid_in,
    input  logic               upd_invalid_in,
    output board_t             board_out,
    output logic               turn_out,
    output logic               ack_out,
    output logic               nack_out,
    output logic [2:0]         nack_code_out,
    output logic               game_over_out,
    output logic [COUNT_W-1:0] move_count_out
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_ISSUE, S_WAIT,
        S_COMMIT, S_PASS, S_REJECT, S_OVER
    } state_t;

    state_t             state_q;
    board_t             board_q;
    board_t             ko_q;
    logic               turn_q;
    logic [1:0]         streak_q;
    logic [COUNT_W-1:0] count_q;
    logic               player_q;
    logic               pass_q;
    logic [7:0]         move_q;
    logic [TW-1:0]      timer_q;
    nack_code_t         rej_q;
    nack_code_t         code_q;
    logic               ack_q;
    logic               nack_q;

    logic [3:0] row;
    logic [3:0] col;
    logic       game_clr;

    assign row = move_q[7:4];
    assign col = move_q[3:0];
    assign game_clr = new_game_in && (state_q == S_IDLE || state_q == S_OVER);

    always_ff @(posedge clk_in) begin
        if (!rst_in || game_clr) begin
            state_q  <= S_IDLE;
            board_q  <= EMPTY_BOARD;
            ko_q     <= EMPTY_BOARD;
            turn_q   <= 1'b0;
            streak_q <= '0;
            count_q  <= '0;
            player_q <= 1'b0;
            pass_q   <= 1'b0;
            move_q   <= '0;
            timer_q  <= '0;
            rej_q    <= OFF_BOARD;
            code_q   <= OFF_BOARD;
            ack_q    <= 1'b0;
            nack_q   <= 1'b0;
        end else begin
            ack_q  <= 1'b0;
            nack_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (req_valid_in) begin
                        player_q <= req_player_in;
                        pass_q   <= req_pass_in;
                        move_q   <= req_move_in;
                        state_q  <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    // Cheap checks first; only a plausible move reaches the updater.
                    if (player_q != turn_q) begin
                        rej_q   <= WRONG_PLAYER;
                        state_q <= S_REJECT;
                    end else if (pass_q) begin
                        state_q <= S_PASS;
                    end else if (row > 4'd8 || col > 4'd8) begin
                        rej_q   <= OFF_BOARD;
                        state_q <= S_REJECT;
                    end else if (board_q[row][col] != CELL_EMPTY) begin
                        rej_q   <= OCCUPIED;
                        state_q <= S_REJECT;
                    end else begin
                        state_q <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    timer_q <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (upd_invalid_in) begin
                        rej_q   <= ILLEGAL;
                        state_q <= S_REJECT;
                    end else if (upd_valid_in) begin
                        state_q <= S_COMMIT;
                    end else if (timer_q == TIMER_LAST) begin
                        rej_q   <= TIMEOUT;
                        state_q <= S_REJECT;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                S_COMMIT: begin
                    ko_q     <= board_q;
                    board_q  <= upd_next_board_in;
                    turn_q   <= ~turn_q;
                    streak_q <= '0;
                    ack_q    <= 1'b1;
                    if (count_q != '1) count_q <= count_q + 1'b1;
                    state_q  <= S_IDLE;
                end
                S_PASS: begin
                    ko_q     <= board_q;
                    turn_q   <= ~turn_q;
                    streak_q <= streak_q + 2'd1;
                    ack_q    <= 1'b1;
                    state_q  <= (streak_q == 2'd1) ? S_OVER : S_IDLE;
                end
                S_REJECT: begin
                    nack_q  <= 1'b1;
                    code_q  <= rej_q;
                    state_q <= S_IDLE;
                end
                S_OVER: begin
                    state_q <= S_OVER;
                end
            endcase
        end
    end

    assign req_ready_out  = (state_q == S_IDLE);
    assign upd_start_out  = (state_q == S_ISSUE);
    assign game_over_out  = (state_q == S_OVER);
    assign upd_turn_out   = turn_q;
    assign upd_move_out   = move_q;
    assign upd_board_out  = board_q;
    assign upd_ko_out     = ko_q;
    assign board_out      = board_q;
    assign turn_out       = turn_q;
    assign ack_out        = ack_q;
    assign nack_out       = nack_q;
    assign nack_code_out  = code_q;
    assign move_count_out = count_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Bench for game_sequencer: directed scenarios plus random requests
// against a behavioural Go-rules model with a scripted updater stub.
module tb_game_sequencer;
    import go_pkg::*;

    localparam int TO = 16;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          new_game = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_player = 1'b0;
    logic          req_pass = 1'b0;
    logic [7:0]    req_move = '0;
    logic          upd_start;
    logic          upd_turn;
    logic [7:0]    upd_move;
    board_t        upd_board;
    board_t        upd_ko;
    board_t        stub_next = '0;
    logic          upd_valid = 1'b0;
    logic          upd_invalid = 1'b0;
    board_t        board;
    logic          turn;
    logic          ack;
    logic          nack;
    logic [2:0]    nack_code;
    logic          game_over;
    logic [CW-1:0] move_count;

    always #5 clk = ~clk;

    game_sequencer #(.TIMEOUT_CYCLES(TO), .COUNT_W(CW)) dut (
        .clk_in(clk), .rst_in(rst_n), .new_game_in(new_game),
        .req_valid_in(req_valid), .req_ready_out(req_ready),
        .req_player_in(req_player), .req_pass_in(req_pass),
        .req_move_in(req_move), .upd_start_out(upd_start),
        .upd_turn_out(upd_turn), .upd_move_out(upd_move),
        .upd_board_out(upd_board), .upd_ko_out(upd_ko),
        .upd_next_board_in(stub_next), .upd_valid_in(upd_valid),
        .upd_invalid_in(upd_invalid), .board_out(board),
        .turn_out(turn), .ack_out(ack), .nack_out(nack),
        .nack_code_out(nack_code), .game_over_out(game_over),
        .move_count_out(move_count)
    );

    int n_tests = 0;
    int n_fail = 0;

    // Model state: cells as 0 empty, 1 black, 2 white.
    int mb[9][9];
    int mk[9][9];
    int m_turn, m_streak, m_count, m_code;
    bit m_over;

    task automatic check(input string tag, input logic [255:0] got,
                         input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic board_t pack_board(input int a[9][9]);
        board_t b;
        for (int i = 0; i < 9; i++)
            for (int j = 0; j < 9; j++)
                b[i][j] = cell_t'(a[i][j]);
        return b;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 9; i++)
            for (int j = 0; j < 9; j++) begin
                mb[i][j] = 0;
                mk[i][j] = 0;
            end
        m_turn = 0; m_streak = 0; m_count = 0; m_code = 0; m_over = 0;
    endtask

    task automatic check_state(input string tag);
        check({tag, "_board"}, board, pack_board(mb));
        check({tag, "_ko"}, upd_ko, pack_board(mk));
        check({tag, "_turn"}, turn, m_turn);
        check({tag, "_count"}, move_count, m_count);
        check({tag, "_code"}, nack_code, m_code);
        check({tag, "_over"}, game_over, m_over);
    endtask

    task automatic run_req(input bit pl, input bit ps, input logic [7:0] mv,
                           input int mode, input int dly, input bit cap);
        int r, c, rr, cc, code, starts, st_t, resp_t;
        bit exp_ack, exp_start, done, got_ack, got_nack;
        int nb[9][9];
        r = int'(mv[7:4]);
        c = int'(mv[3:0]);
        nb = mb;
        code = -1; exp_ack = 0; exp_start = 0;
        if (pl != m_turn[0]) code = 4;
        else if (ps) exp_ack = 1;
        else if (r > 8 || c > 8) code = 0;
        else if (mb[r][c] != 0) code = 1;
        else begin
            exp_start = 1;
            if (mode == 0) begin
                exp_ack = 1;
                nb[r][c] = m_turn + 1;
                if (cap) begin
                    rr = $urandom_range(8, 0);
                    cc = $urandom_range(8, 0);
                    if (!(rr == r && cc == c)) nb[rr][cc] = 0;
                end
            end else begin
                code = (mode == 1) ? 2 : 3;
            end
        end
        stub_next = pack_board(nb);
        starts = 0; st_t = 0; resp_t = 0; done = 0;
        got_ack = 0; got_nack = 0;
        req_valid = 1'b1; req_player = pl; req_pass = ps; req_move = mv;
        for (int t = 1; t <= 200 && !done; t++) begin
            @(negedge clk);
            if (t == 1) req_valid = 1'b0;
            upd_valid = 1'b0;
            upd_invalid = 1'b0;
            if (upd_start) begin
                starts++;
                st_t = t;
                check("upd_move", upd_move, mv);
                check("upd_turn", upd_turn, m_turn);
                check("upd_board", upd_board, pack_board(mb));
                check("upd_ko_in", upd_ko, pack_board(mk));
            end
            if (st_t > 0 && mode < 2 && t == st_t + dly) begin
                if (mode == 0) upd_valid = 1'b1;
                else begin
                    upd_invalid = 1'b1;
                    upd_valid = 1'($urandom_range(1, 0));
                end
            end
            if (ack || nack) begin
                done = 1; resp_t = t; got_ack = ack; got_nack = nack;
            end
        end
        upd_valid = 1'b0;
        upd_invalid = 1'b0;
        check("resp_seen", done, 1);
        check("ack", got_ack, exp_ack);
        check("nack", got_nack, code >= 0);
        check("starts", starts, exp_start);
        if (exp_start)
            check("lat_upd", resp_t - st_t, (mode == 2) ? TO + 2 : dly + 2);
        else
            check("lat_imm", resp_t, 3);
        if (code >= 0) begin
            m_code = code;
        end else if (ps) begin
            mk = mb;
            m_turn ^= 1;
            m_streak++;
            if (m_streak == 2) m_over = 1;
        end else begin
            mk = mb;
            mb = nb;
            m_turn ^= 1;
            m_streak = 0;
            if (m_count < (1 << CW) - 1) m_count++;
        end
        check_state("req");
        @(negedge clk);
        check("pulse_end", {ack, nack}, 2'b00);
        check("ready", req_ready, !m_over);
    endtask

    task automatic ignored_req();
        int seen = 0;
        req_valid = 1'b1; req_player = m_turn[0]; req_pass = 1'b0;
        req_move = 8'h12;
        repeat (4) begin
            @(negedge clk);
            if (ack || nack) seen++;
        end
        req_valid = 1'b0;
        check("over_ignore", seen, 0);
        check("over_flag", game_over, m_over);
        check("over_ready", req_ready, !m_over);
    endtask

    task automatic do_new_game();
        int seen = 0;
        new_game = 1'b1;
        req_valid = 1'b1; req_player = m_turn[0]; req_pass = 1'b0;
        req_move = 8'h00;
        @(negedge clk);
        new_game = 1'b0;
        req_valid = 1'b0;
        model_clear();
        repeat (3) begin
            @(negedge clk);
            if (ack || nack) seen++;
        end
        check("ng_pulses", seen, 0);
        check("ng_ready", req_ready, 1);
        check_state("ng");
    endtask

    task automatic stray_test();
        int seen = 0;
        stub_next = board_t'({$urandom(), $urandom(), $urandom(),
                              $urandom(), $urandom(), $urandom()});
        upd_valid = 1'b1;
        upd_invalid = 1'($urandom_range(1, 0));
        repeat (2) begin
            @(negedge clk);
            if (ack || nack) seen++;
        end
        upd_valid = 1'b0;
        upd_invalid = 1'b0;
        @(negedge clk);
        check("stray_pulses", seen, 0);
        check_state("stray");
    endtask

    initial begin
        logic [3:0] rr, cc;
        int x;
        model_clear();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_state("rst");
        check("rst_ready", req_ready, 1);
        check("rst_pulses", {ack, nack, upd_start}, 3'b000);

        run_req(0, 0, 8'h44, 0, 2, 0);
        check("b44", board[4][4], 2'b01);
        run_req(1, 0, 8'h44, 0, 1, 0);
        run_req(1, 0, 8'h93, 0, 1, 0);
        run_req(0, 0, 8'h22, 0, 1, 0);
        run_req(1, 0, 8'h35, 1, 5, 0);
        run_req(1, 0, 8'h36, 2, 1, 0);
        stray_test();
        run_req(1, 0, 8'h88, 0, 3, 0);
        run_req(0, 0, 8'h89, 0, 1, 0);
        run_req(0, 1, 8'h00, 0, 1, 0);
        run_req(1, 1, 8'h00, 0, 1, 0);
        ignored_req();
        do_new_game();

        // Pass, move, pass must not end the game; then saturate the counter.
        run_req(0, 1, 8'h00, 0, 1, 0);
        run_req(1, 0, 8'h01, 0, 1, 0);
        run_req(0, 1, 8'h00, 0, 1, 0);
        for (int i = 0; i < 17; i++)
            run_req(m_turn[0], 0, {4'(i / 9 + 2), 4'(i % 9)}, 0, 1, 0);

        // Reset in the middle of an updater transaction.
        req_valid = 1'b1; req_player = m_turn[0]; req_pass = 1'b0;
        req_move = 8'h55;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        @(negedge clk);
        check_state("midrst");
        check("midrst_ready", req_ready, 1);
        check("midrst_pulses", {ack, nack, upd_start}, 3'b000);

        for (int i = 0; i < 90; i++) begin
            if (m_over) begin
                if ($urandom_range(1, 0) == 1) ignored_req();
                do_new_game();
            end else if ($urandom_range(39, 0) == 0) begin
                do_new_game();
            end else begin
                rr = ($urandom_range(7, 0) == 0) ? 4'($urandom_range(15, 0))
                                                 : 4'($urandom_range(8, 0));
                cc = ($urandom_range(7, 0) == 0) ? 4'($urandom_range(15, 0))
                                                 : 4'($urandom_range(8, 0));
                x = $urandom_range(9, 0);
                run_req(($urandom_range(4, 0) == 0) ? ~m_turn[0] : m_turn[0],
                        ($urandom_range(9, 0) == 0), {rr, cc},
                        (x < 7) ? 0 : (x < 9) ? 1 : 2,
                        $urandom_range(6, 1), 1'($urandom_range(1, 0)));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
